// File: rtl/factorial_sched.sv
// Request scheduler in front of a factorial core: queues operands in a FIFO,
// runs one job at a time through the core and returns each result on a valid/ready port.
module factorial_sched #(
  parameter int SIZE    = 8,
  parameter int DEPTH   = 4,
  parameter int MAX_N   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [SIZE-1:0]          req_n,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [SIZE-1:0]          rsp_result,
  output logic                     rsp_err,
  output logic                     fact_go,
  output logic [SIZE-1:0]          fact_n,
  input  logic                     fact_done,
  input  logic [SIZE-1:0]          fact_result,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_RESP} state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [SIZE-1:0]  fact_n_q, fact_n_d, rsp_result_q, rsp_result_d;
  logic             rsp_err_q, rsp_err_d, rsp_valid_q, rsp_valid_d;
  logic             fact_go_q, fact_go_d, busy_q, busy_d;
  logic             push, pop;
  logic [SIZE-1:0]  mem_q [DEPTH];
  logic [SIZE-1:0]  head;

  assign req_ready = (count_q < CNT_W'(DEPTH));
  assign push      = req_valid & req_ready;
  assign head      = mem_q[rd_ptr_q];

  // NOTE: the storage array has no reset; count_q alone says which entries are valid,
  // so resetting the data would only cost flops and buy nothing.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= req_n;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    tmo_d        = tmo_q;
    fact_n_d     = fact_n_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          pop = 1'b1;
          if (head > SIZE'(MAX_N)) begin
            rsp_result_d = '0;
            rsp_err_d    = 1'b1;
            state_d      = ST_RESP;
          end else begin
            fact_n_d = head;
            state_d  = ST_LAUNCH;
          end
        end
      end
      ST_LAUNCH: begin
        tmo_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        tmo_d = tmo_q + TMO_W'(1);
        // tmo_q == 0 is the first WAIT cycle: a done seen there belongs to the previous job.
        if (fact_done && tmo_q != '0) begin
          rsp_result_d = fact_result;
          rsp_err_d    = 1'b0;
          state_d      = ST_RESP;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          rsp_result_d = '0;
          rsp_err_d    = 1'b1;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    fact_go_d   = (state_d == ST_LAUNCH);
    rsp_valid_d = (state_d == ST_RESP);
    busy_d      = (state_d != ST_IDLE);
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      tmo_q        <= '0;
      fact_n_q     <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      fact_go_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      tmo_q        <= tmo_d;
      fact_n_q     <= fact_n_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      rsp_valid_q  <= rsp_valid_d;
      fact_go_q    <= fact_go_d;
      busy_q       <= busy_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;
  assign fact_go    = fact_go_q;
  assign fact_n     = fact_n_q;
  assign busy       = busy_q;
  assign count      = count_q;

endmodule
